// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes bitstream words onto a configuration chain's ccff_head.
// Optional readback CRC of ccff_tail is built when CCFF_LOADER_READBACK_EN is defined.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 58,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [15:0]       readback_crc
);

    localparam int RW = $clog2(CHAIN_LEN + 1);
    localparam int KW = $clog2(WORD_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [RW-1:0] R_ONE = RW'(1);
    localparam logic [KW-1:0] K_ONE = KW'(1);

    logic [1:0]        r_state;
    logic [RW-1:0]     r_remaining;
    logic [KW-1:0]     r_k;
    logic [WORD_W-1:0] r_buf;
    logic [KW-1:0]     w_k;

    // Last word of the chain may be partial: only the bits still needed are shifted.
    always_comb begin
        w_k = (32'(r_remaining) >= WORD_W) ? KW'(WORD_W) : KW'(r_remaining);
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_k         <= '0;
            r_buf       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_FETCH;
                        r_remaining <= RW'(CHAIN_LEN);
                    end
                end
                S_FETCH: begin
                    if (word_valid) begin
                        r_buf   <= word_in;
                        r_k     <= w_k;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_buf       <= r_buf << 1;
                    r_k         <= r_k - K_ONE;
                    r_remaining <= r_remaining - R_ONE;
                    if (r_k == K_ONE) begin
                        r_state <= (r_remaining == R_ONE) ? S_DONE : S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so reset drops shift_en without a clock.
    assign word_ready    = (r_state == S_FETCH);
    assign ccff_shift_en = (r_state == S_SHIFT);
    assign ccff_head     = ccff_shift_en & r_buf[WORD_W-1];
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);

`ifdef CCFF_LOADER_READBACK_EN
    logic [15:0] r_crc;
    logic        w_fb;

    assign w_fb = r_crc[15] ^ ccff_tail;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_crc <= 16'hFFFF;
        end else if ((r_state == S_IDLE) && start) begin
            r_crc <= 16'hFFFF;
        end else if (ccff_shift_en) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
        end
    end

    assign readback_crc = r_crc;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign readback_crc  = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - randomized self-checking bench for ccff_chain_loader.
module tb_ccff_chain_loader;

    localparam int CL = 58;
    localparam int WW = 8;
    localparam int NW = (CL + WW - 1) / WW;

    logic          prog_clk = 1'b0;
    logic          pReset = 1'b0;
    logic          start = 1'b0;
    logic [WW-1:0] word_in = '0;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail = 1'b0;
    logic          busy;
    logic          done;
    logic [15:0]   readback_crc;

    logic          s_start = 1'b0;
    logic [0:0]    s_word_in = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_head;
    logic          s_shift_en;
    logic          s_tail = 1'b0;
    logic          s_busy;
    logic          s_done;
    logic [15:0]   s_crc;

    int tests = 0;
    int fails = 0;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .word_in(word_in),
        .word_valid(word_valid), .word_ready(word_ready), .ccff_head(ccff_head),
        .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy),
        .done(done), .readback_crc(readback_crc)
    );

    ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(1)) dut_small (
        .prog_clk(prog_clk), .pReset(pReset), .start(s_start), .word_in(s_word_in),
        .word_valid(s_valid), .word_ready(s_ready), .ccff_head(s_head),
        .ccff_shift_en(s_shift_en), .ccff_tail(s_tail), .busy(s_busy),
        .done(s_done), .readback_crc(s_crc)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_of(input bit b[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i]) begin
            c = (c << 1) ^ ((c[15] ^ b[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic run_load(input string tag, input bit directed, input int stall_at,
                            input int stall_len, input bit poke_start, input int abort_at);
        logic [WW-1:0] words[$];
        bit            tails[$];
        logic [63:0]   exp_v = '0;
        logic [63:0]   got_v = '0;
        int            nbits = 0;
        int            widx = 0;
        int            hs = 0;
        int            stalls = 0;
        int            done_c = -1;
        int            extra_done = 0;
        logic          stall_shift = 1'b0;
        for (int i = 0; i < NW; i++) begin
            int k;
            if (directed) words.push_back((i == NW - 1) ? 8'hC0 : 8'hA5);
            else          words.push_back(WW'($urandom));
            k = (CL - i * WW < WW) ? (CL - i * WW) : WW;
            for (int b = 0; b < k; b++) exp_v = {exp_v[62:0], words[i][WW-1-b]};
        end
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        for (int c = 1; c <= 600; c++) begin
            if (c > 1) @(negedge prog_clk);
            if (c == 1) begin
                chk({tag, "_busy_fetch"}, busy, 1);
                chk({tag, "_ready_fetch"}, word_ready, 1);
            end
            if (directed && c == 2) chk({tag, "_first_shift"}, ccff_shift_en, 1);
            if (done) begin
                done_c = c;
                break;
            end
            start = 1'b0;
            ccff_tail = 1'($urandom);
            if (ccff_shift_en) begin
                got_v = {got_v[62:0], ccff_head};
                nbits++;
                tails.push_back(ccff_tail);
            end
            if (abort_at > 0 && nbits == abort_at && ccff_shift_en) begin
                word_valid = 1'b0;
                #2 pReset = 1'b0;
                #1;
                chk({tag, "_abort_shift_en"}, ccff_shift_en, 0);
                chk({tag, "_abort_busy"}, busy, 0);
                @(posedge prog_clk);
                #1 pReset = 1'b1;
                return;
            end
            if (poke_start && nbits == 10 && ccff_shift_en) start = 1'b1;
            if (word_ready && widx == stall_at && stalls < stall_len) begin
                word_valid = 1'b0;
                stalls++;
                stall_shift = stall_shift | ccff_shift_en;
            end else begin
                word_valid = 1'b1;
            end
            word_in = (widx < NW) ? words[widx] : WW'($urandom);
            if (word_valid && word_ready) begin
                hs++;
                widx++;
            end
        end
        word_valid = 1'b0;
        start = 1'b0;
        chk({tag, "_done_cycle"}, done_c, NW + CL + stall_len + 1);
        chk({tag, "_handshakes"}, hs, NW);
        chk({tag, "_bit_count"}, nbits, CL);
        chk({tag, "_bits"}, got_v, exp_v);
        if (directed) chk({tag, "_pattern"}, got_v, {6'h0, 56'hA5A5A5A5A5A5A5, 2'b11});
        if (stall_len > 0) chk({tag, "_stall_shift_en"}, stall_shift, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge prog_clk);
            if (done) extra_done++;
        end
        chk({tag, "_single_done"}, extra_done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
`ifdef CCFF_LOADER_READBACK_EN
        chk({tag, "_crc"}, readback_crc, crc_of(tails));
`else
        chk({tag, "_crc"}, readback_crc, 16'h0000);
`endif
    endtask

    initial begin
        int s_done_c;
        pReset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge prog_clk);
            start      = 1'($urandom);
            word_valid = 1'($urandom);
            word_in    = WW'($urandom);
            ccff_tail  = 1'($urandom);
        end
        start = 1'b1;
        @(negedge prog_clk);
        chk("rst_word_ready", word_ready, 0);
        chk("rst_head", ccff_head, 0);
        chk("rst_shift_en", ccff_shift_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef CCFF_LOADER_READBACK_EN
        chk("rst_crc", readback_crc, 16'hFFFF);
`else
        chk("rst_crc", readback_crc, 16'h0000);
`endif
        start = 1'b0;
        word_valid = 1'b0;
        pReset = 1'b1;
        @(negedge prog_clk);
        @(negedge prog_clk);
        chk("rst_start_ignored", busy, 0);

        run_load("full", 1'b1, -1, 0, 1'b0, 0);
        run_load("stall", 1'b0, 3, 5, 1'b0, 0);
        run_load("poke", 1'b0, -1, 0, 1'b1, 0);
        run_load("again", 1'b0, -1, 0, 1'b0, 0);
        run_load("abort", 1'b0, -1, 0, 1'b0, 20);
        run_load("post_abort", 1'b0, -1, 0, 1'b0, 0);

        @(negedge prog_clk);
        s_start = 1'b1;
        s_valid = 1'b1;
        s_word_in = 1'b1;
        s_tail = 1'b0;
        @(negedge prog_clk);
        s_start = 1'b0;
        s_done_c = -1;
        for (int c = 1; c <= 20; c++) begin
            if (s_done) begin
                s_done_c = c;
                break;
            end
            @(negedge prog_clk);
        end
        s_valid = 1'b0;
        chk("small_done_cycle", s_done_c, 3);
        @(negedge prog_clk);
`ifdef CCFF_LOADER_READBACK_EN
        chk("small_crc", s_crc, 16'hEFDF);
`else
        chk("small_crc", s_crc, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
